// File: rtl/cpu_pkg.sv
// Shared CPU definitions: memory-access FSM states, access size codes and the
// alignment check used by both the store and load-extract paths.
package cpu_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD,
      ST_WAIT,
      ST_WR,
      ST_DONE
   } state_t;

   localparam logic [1:0] SZ_WORD = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_BYTE = 2'b10;
   localparam logic [1:0] SZ_RSVD = 2'b11;

   // High for a reserved size or an access that does not sit on its natural boundary.
   function automatic logic access_fault(input logic [1:0] size, input logic [1:0] addr_lo);
      logic bad;
      case (size)
         SZ_WORD: bad = (addr_lo != 2'b00);
         SZ_HALF: bad = addr_lo[0];
         SZ_BYTE: bad = 1'b0;
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/store_merge.sv
// Little-endian sub-word merge: places the low bytes of data into the lanes of
// old_word selected by size and addr_lo.
module store_merge
   import cpu_pkg::*;
(
   input  logic [31:0] old_word,
   input  logic [31:0] data,
   input  logic [1:0]  size,
   input  logic [1:0]  addr_lo,
   output logic [31:0] merged
);

   always_comb begin
      merged = old_word;
      case (size)
         SZ_WORD: merged = data;
         SZ_HALF: begin
            if (addr_lo[1]) merged[31:16] = data[15:0];
            else            merged[15:0]  = data[15:0];
         end
         SZ_BYTE: begin
            case (addr_lo)
               2'd0:    merged[7:0]   = data[7:0];
               2'd1:    merged[15:8]  = data[7:0];
               2'd2:    merged[23:16] = data[7:0];
               default: merged[31:24] = data[7:0];
            endcase
         end
         default: merged = old_word;
      endcase
   end

endmodule

// File: rtl/store_ctrl.sv
// Store sequencer: full-word stores write directly, halfword/byte stores do a
// read-modify-write of the containing word; misaligned or reserved sizes fault.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | waiting for start; operands latched on the accepting edge
// ST_RD   | word address presented for the read
// ST_WAIT | read data valid; captured into old_q at the end of the cycle
// ST_WR   | one-cycle write of the merged word
// ST_DONE | completion pulse; fault also pulses here for rejected stores
module store_ctrl
   import cpu_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  size,
   input  logic [31:0] addr,
   input  logic [31:0] store_data,
   input  logic [31:0] mem_rdata,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_wr,
   output logic        busy,
   output logic        done,
   output logic        fault
);

   state_t      state;
   state_t      state_nxt;
   logic [31:0] addr_q;
   logic [31:0] data_q;
   logic [31:0] old_q;
   logic [1:0]  size_q;
   logic [31:0] merged;
   logic        accept;

   assign accept = (state == ST_IDLE) && start;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state  <= ST_IDLE;
         addr_q <= '0;
         size_q <= '0;
         data_q <= '0;
         old_q  <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            addr_q <= addr;
            size_q <= size;
            data_q <= store_data;
         end
         if (state == ST_WAIT) old_q <= mem_rdata;
      end
   end

   store_merge u_merge (
      .old_word (old_q),
      .data     (data_q),
      .size     (size_q),
      .addr_lo  (addr_q[1:0]),
      .merged   (merged)
   );

   always_comb begin
      state_nxt = state;
      mem_addr  = {addr_q[31:2], 2'b00};
      mem_wdata = '0;
      mem_wr    = 1'b0;
      busy      = 1'b1;
      done      = 1'b0;
      fault     = 1'b0;
      case (state)
         ST_IDLE: begin
            busy = 1'b0;
            if (start) begin
               if (access_fault(size, addr[1:0])) state_nxt = ST_DONE;
               else if (size == SZ_WORD)          state_nxt = ST_WR;
               else                               state_nxt = ST_RD;
            end
         end
         ST_RD:   state_nxt = ST_WAIT;
         ST_WAIT: state_nxt = ST_WR;
         ST_WR: begin
            mem_wr    = 1'b1;
            mem_wdata = merged;
            state_nxt = ST_DONE;
         end
         ST_DONE: begin
            done      = 1'b1;
            // Operands are still held, so the fault can be re-derived here.
            fault     = access_fault(size_q, addr_q[1:0]);
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_store_ctrl.sv
// Directed bench for store_ctrl: hand-computed store vectors, faults, reset abort
// and start-while-busy, each checked cycle by cycle against expected latencies.
module tb_store_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  size;
   logic [31:0] addr;
   logic [31:0] store_data;
   logic [31:0] mem_rdata;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_wr;
   logic        busy;
   logic        done;
   logic        fault;

   int n_cmp = 0;
   int n_bad = 0;

   store_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .size       (size),
      .addr       (addr),
      .store_data (store_data),
      .mem_rdata  (mem_rdata),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_wr     (mem_wr),
      .busy       (busy),
      .done       (done),
      .fault      (fault)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issues one store at the current cycle (T) and watches it for up to 8 cycles.
   task automatic do_store(input string tag, input logic [1:0] sz, input logic [31:0] a,
                           input logic [31:0] d, input logic [31:0] rd,
                           input int exp_wr_cyc, input int exp_done_cyc,
                           input logic [31:0] exp_waddr, input logic [31:0] exp_wdata,
                           input logic exp_fault, input bit disturb);
      int          wr_cyc = -1;
      int          done_cyc = -1;
      int          nwr = 0;
      int          zerr = 0;
      int          ferr = 0;
      int          aerr = 0;
      int          berr = 0;
      logic [31:0] waddr = '0;
      logic [31:0] wdata = '0;
      logic        fseen = 1'b0;
      start      = 1'b1;
      size       = sz;
      addr       = a;
      store_data = d;
      mem_rdata  = 32'h5A5A5A5A;
      step();
      for (int c = 1; c <= 8; c++) begin
         if (mem_wr) begin
            nwr++;
            wr_cyc = c;
            waddr  = mem_addr;
            wdata  = mem_wdata;
         end else if (mem_wdata != 32'h0) zerr++;
         if (fault && !done) ferr++;
         if (!busy) berr++;
         if (!exp_fault && !done && mem_addr != exp_waddr) aerr++;
         if (done) begin
            done_cyc = c;
            fseen    = fault;
         end
         mem_rdata = (c == 2) ? rd : (32'hC0DE0000 | 32'(c));
         if (disturb) begin
            start      = 1'b1;
            addr       = $urandom;
            store_data = $urandom;
            size       = 2'($urandom_range(0, 3));
         end else begin
            start = 1'b0;
         end
         step();
         if (done_cyc > 0) break;
      end
      start = 1'b0;
      chk({tag, " wr_count"}, 32'(nwr), exp_fault ? 32'd0 : 32'd1);
      chk({tag, " wr_cycle"}, 32'(wr_cyc), 32'(exp_wr_cyc));
      chk({tag, " done_cycle"}, 32'(done_cyc), 32'(exp_done_cyc));
      chk({tag, " fault"}, {31'b0, fseen}, {31'b0, exp_fault});
      chk({tag, " fault_outside_done"}, 32'(ferr), 32'd0);
      chk({tag, " wdata_nonzero_idle"}, 32'(zerr), 32'd0);
      chk({tag, " busy_low_inflight"}, 32'(berr), 32'd0);
      chk({tag, " after_busy"}, {31'b0, busy}, 32'd0);
      chk({tag, " after_done"}, {31'b0, done}, 32'd0);
      if (!exp_fault) begin
         chk({tag, " mem_addr_unstable"}, 32'(aerr), 32'd0);
         chk({tag, " mem_addr"}, waddr, exp_waddr);
         chk({tag, " mem_wdata"}, wdata, exp_wdata);
      end
   endtask

   initial begin
      int nwr_rst;
      reset      = 1'b0;
      start      = 1'b1;
      size       = 2'b00;
      addr       = 32'h100;
      store_data = 32'hFFFFFFFF;
      mem_rdata  = 32'h0;
      step();
      step();
      chk("rst busy", {31'b0, busy}, 32'd0);
      chk("rst done", {31'b0, done}, 32'd0);
      chk("rst fault", {31'b0, fault}, 32'd0);
      chk("rst mem_wr", {31'b0, mem_wr}, 32'd0);
      chk("rst mem_addr", mem_addr, 32'h0);
      chk("rst mem_wdata", mem_wdata, 32'h0);
      start = 1'b0;
      reset = 1'b1;
      step();

      do_store("sw",      2'b00, 32'h100, 32'h12345678, 32'h0,        1, 2, 32'h100, 32'h12345678, 1'b0, 1'b0);
      do_store("sw_b2b",  2'b00, 32'h204, 32'h9ABCDEF0, 32'h0,        1, 2, 32'h204, 32'h9ABCDEF0, 1'b0, 1'b0);
      do_store("sb_l2",   2'b10, 32'h102, 32'h000000EE, 32'hAABBCCDD, 3, 4, 32'h100, 32'hAAEECCDD, 1'b0, 1'b0);
      do_store("sh_hi",   2'b01, 32'h106, 32'h0000BEEF, 32'hAABBCCDD, 3, 4, 32'h104, 32'hBEEFCCDD, 1'b0, 1'b0);
      do_store("sh_lo",   2'b01, 32'h200, 32'hFFFF1234, 32'hAABBCCDD, 3, 4, 32'h200, 32'hAABB1234, 1'b0, 1'b0);
      do_store("sb_l3",   2'b10, 32'h203, 32'h12345655, 32'h01020304, 3, 4, 32'h200, 32'h55020304, 1'b0, 1'b0);
      do_store("sb_l0",   2'b10, 32'h100, 32'hFFFFFF77, 32'hAABBCCDD, 3, 4, 32'h100, 32'hAABBCC77, 1'b0, 1'b0);
      do_store("sb_l1",   2'b10, 32'h105, 32'h00000011, 32'hAABBCCDD, 3, 4, 32'h104, 32'hAABB11DD, 1'b0, 1'b0);
      do_store("f_sh",    2'b01, 32'h101, 32'h0000BEEF, 32'h0,       -1, 1, 32'h0,   32'h0,        1'b1, 1'b0);
      do_store("f_sw",    2'b00, 32'h102, 32'h12345678, 32'h0,       -1, 1, 32'h0,   32'h0,        1'b1, 1'b0);
      do_store("f_rsvd",  2'b11, 32'h100, 32'h12345678, 32'h0,       -1, 1, 32'h0,   32'h0,        1'b1, 1'b0);
      do_store("sh_busy", 2'b01, 32'h106, 32'h0000BEEF, 32'hAABBCCDD, 3, 4, 32'h104, 32'hBEEFCCDD, 1'b0, 1'b1);

      // Reset in the WAIT cycle of a byte store must abort it without a write.
      start      = 1'b1;
      size       = 2'b10;
      addr       = 32'h102;
      store_data = 32'hEE;
      step();
      start     = 1'b0;
      mem_rdata = 32'h11111111;
      step();
      reset     = 1'b0;
      mem_rdata = 32'hAABBCCDD;
      step();
      chk("abort busy", {31'b0, busy}, 32'd0);
      chk("abort mem_wr", {31'b0, mem_wr}, 32'd0);
      chk("abort done", {31'b0, done}, 32'd0);
      chk("abort mem_addr", mem_addr, 32'h0);
      chk("abort mem_wdata", mem_wdata, 32'h0);
      reset   = 1'b1;
      nwr_rst = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (mem_wr || busy) nwr_rst++;
      end
      chk("abort quiet", 32'(nwr_rst), 32'd0);
      do_store("sw_post", 2'b00, 32'h300, 32'hCAFEF00D, 32'h0, 1, 2, 32'h300, 32'hCAFEF00D, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
